// File: rtl/dcache_if.sv
// Bus bundle for the data cache: CPU load/store side and line-wide
// memory side. The cache takes the slave view; the CPU/memory agent
// takes the master view.
interface dcache_if;
    // CPU side
    logic [31:0]  data_addr;
    logic         data_read;
    logic         data_write;
    logic [3:0]   data_mbe;
    logic [31:0]  data_wdata;
    logic [31:0]  data_rdata;
    logic         data_resp;
    // Memory side
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  data_addr, data_read, data_write, data_mbe, data_wdata,
        output data_rdata, data_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output data_addr, data_read, data_write, data_mbe, data_wdata,
        input  data_rdata, data_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache with 32-byte lines.
// A four-state FSM (IDLE/CHECK/WRITEBACK/ALLOCATE) sequences lookups,
// dirty-line writebacks and line fills. Valid/dirty bits and the FSM are
// reset; tag and line storage are not.
module dcache #(
    parameter int S_INDEX = 3
) (
    input  logic clk,
    input  logic rst,
    dcache_if.slave bus
);
    localparam int NSETS = 1 << S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, ALLOCATE} state_t;

    state_t             state_q, state_d;
    logic [NSETS-1:0]   valid_q, dirty_q;
    logic [TAG_W-1:0]   tag_q  [NSETS];
    logic [255:0]       line_q [NSETS];

    logic [TAG_W-1:0]   addr_tag;
    logic [S_INDEX-1:0] addr_idx;
    logic [2:0]         addr_word;
    logic               req, hit;
    logic [255:0]       cur_line;
    logic [31:0]        cur_word;
    logic               unused_addr_bits;

    logic               fill_we, store_we, wb_done;
    logic [31:0]        rdata_o;
    logic               resp_o;
    logic [31:0]        paddr_o;
    logic               pread_o, pwrite_o;
    logic [255:0]       pwdata_o;

    // Replace the enabled bytes of one word inside a line.
    function automatic logic [255:0] merge_store(
        input logic [255:0] line,
        input logic [2:0]   word,
        input logic [3:0]   mbe,
        input logic [31:0]  wdata
    );
        logic [255:0] r;
        r = line;
        for (int b = 0; b < 4; b++) begin
            if (mbe[b]) r[word*32 + b*8 +: 8] = wdata[b*8 +: 8];
        end
        return r;
    endfunction

    assign addr_tag         = bus.data_addr[31:5+S_INDEX];
    assign addr_idx         = bus.data_addr[4+S_INDEX:5];
    assign addr_word        = bus.data_addr[4:2];
    assign unused_addr_bits = ^bus.data_addr[1:0];
    assign req              = bus.data_read | bus.data_write;
    assign cur_line         = line_q[addr_idx];
    assign cur_word         = cur_line[addr_word*32 +: 32];
    assign hit              = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a request dropped mid-miss falls back to IDLE via CHECK.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req) state_d = CHECK;
            CHECK: begin
                if (!req || hit)                            state_d = IDLE;
                else if (valid_q[addr_idx] && dirty_q[addr_idx]) state_d = WRITEBACK;
                else                                        state_d = ALLOCATE;
            end
            WRITEBACK: if (bus.pmem_resp) state_d = ALLOCATE;
            ALLOCATE:  if (bus.pmem_resp) state_d = CHECK;
            default:   state_d = IDLE;
        endcase
    end

    // Output and array-update decode; everything idles at zero by default.
    always_comb begin
        resp_o   = 1'b0;
        rdata_o  = '0;
        pread_o  = 1'b0;
        pwrite_o = 1'b0;
        paddr_o  = '0;
        pwdata_o = '0;
        fill_we  = 1'b0;
        store_we = 1'b0;
        wb_done  = 1'b0;
        case (state_q)
            CHECK: begin
                if (req && hit) begin
                    resp_o   = 1'b1;
                    rdata_o  = cur_word;
                    store_we = bus.data_write;
                end
            end
            WRITEBACK: begin
                pwrite_o = 1'b1;
                paddr_o  = {tag_q[addr_idx], addr_idx, 5'b0};
                pwdata_o = cur_line;
                wb_done  = bus.pmem_resp;
            end
            ALLOCATE: begin
                pread_o = 1'b1;
                paddr_o = {bus.data_addr[31:5], 5'b0};
                fill_we = bus.pmem_resp;
            end
            default: ;
        endcase
    end

    assign bus.data_resp    = resp_o;
    assign bus.data_rdata   = rdata_o;
    assign bus.pmem_read    = pread_o;
    assign bus.pmem_write   = pwrite_o;
    assign bus.pmem_address = paddr_o;
    assign bus.pmem_wdata   = pwdata_o;

    // Valid/dirty bookkeeping: fill marks clean-valid, store dirties, writeback cleans.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (fill_we) begin
                valid_q[addr_idx] <= 1'b1;
                dirty_q[addr_idx] <= 1'b0;
            end else if (store_we) begin
                dirty_q[addr_idx] <= 1'b1;
            end else if (wb_done) begin
                dirty_q[addr_idx] <= 1'b0;
            end
        end
    end

    // Tag and line storage: line fill from memory or byte-merged store hit.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            line_q[addr_idx] <= bus.pmem_rdata;
            tag_q[addr_idx]  <= addr_tag;
        end else if (store_we) begin
            line_q[addr_idx] <= merge_store(cur_line, addr_word, bus.data_mbe, bus.data_wdata);
        end
    end
endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 Parameter: S_INDEX, default 3, set-index width; 2**S_INDEX sets; tag width = 27 - S_INDEX.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 data_addr  in  32  word-aligned CPU address; [1:0] ignored.
REQ-005 data_read  in  1  CPU load request, held until data_resp.
REQ-006 data_write  in  1  CPU store request, held until data_resp.
REQ-007 data_mbe  in  4  byte enables for store; bit i covers data_wdata[8i+7:8i].
REQ-008 data_wdata  in  32  store data.
REQ-009 data_rdata  out  32  load data, valid only while data_resp=1.
REQ-010 data_resp  out  1  one-cycle completion pulse.
REQ-011 pmem_address  out  32  line address; [4:0] always 0.
REQ-012 pmem_read  out  1  line fill request, held until pmem_resp.
REQ-013 pmem_write  out  1  line writeback request, held until pmem_resp.
REQ-014 pmem_wdata  out  256  writeback line data.
REQ-015 pmem_rdata  in  256  fill line data, valid with pmem_resp.
REQ-016 pmem_resp  in  1  one-cycle memory completion pulse.

Function
REQ-017 Organisation: direct-mapped, write-back, write-allocate; 32-byte lines; per set: valid, dirty, tag, 256-bit data.
REQ-018 Address split: tag = addr[31:5+S_INDEX], index = addr[4+S_INDEX:5], word = addr[4:2]; word w occupies line bits [32w+31:32w].
REQ-019 FSM states: IDLE, CHECK, WRITEBACK, ALLOCATE.
REQ-020 IDLE: if data_read or data_write, next state CHECK; else stay; no outputs asserted.
REQ-021 CHECK: hit = valid[index] and tag match.
REQ-022 CHECK hit, read: data_resp=1, data_rdata = selected word, next IDLE; hit latency 2 cycles from request to data_resp.
REQ-023 CHECK hit, write: data_resp=1; at the same edge, bytes with data_mbe=1 replaced, others unchanged; dirty[index] set; next IDLE.
REQ-024 data_read and data_write both high: treated as write; data_rdata shows pre-store word.
REQ-025 data_mbe=0000 on write: completes as a hit/miss normally, data unchanged, dirty still set.
REQ-026 CHECK miss, line invalid or clean: next ALLOCATE; miss, valid and dirty: next WRITEBACK.
REQ-027 WRITEBACK: pmem_write=1, pmem_address = {stored tag, index, 5'b0}, pmem_wdata = stored line; on pmem_resp, clear dirty[index], next ALLOCATE.
REQ-028 ALLOCATE: pmem_read=1, pmem_address = {data_addr[31:5], 5'b0}; on pmem_resp, write pmem_rdata into line, set tag, valid=1, dirty=0, next CHECK (which then hits).
REQ-029 pmem_read and pmem_write never both 1; neither asserted outside ALLOCATE/WRITEBACK.
REQ-030 data_resp never asserted outside CHECK; data_rdata = 0 whenever data_resp=0.
REQ-031 pmem_wdata = 0 outside WRITEBACK.
REQ-032 Back-to-back: a request held high in the cycle after data_resp starts a new transaction (IDLE -> CHECK); no request is completed twice within one data_resp pulse.
REQ-033 CPU request deasserted during WRITEBACK/ALLOCATE: memory transaction still completes; FSM returns to IDLE via CHECK with no data_resp.
REQ-034 pmem_resp outside ALLOCATE/WRITEBACK ignored.

Reset
REQ-035 rst=1 at an edge: state IDLE, all valid and dirty bits 0; data and tag arrays not cleared.
REQ-036 During and after reset until a new request: data_resp, pmem_read, pmem_write = 0; data_rdata, pmem_wdata, pmem_address = 0.
REQ-037 Reset mid-miss abandons the memory transaction; pmem_read/pmem_write low in the cycle after the reset edge; a late pmem_resp is ignored.

Verification
REQ-038 After reset, read 0x0000_0104 -> ALLOCATE with pmem_address 0x0000_0100; pmem_resp with word1 = 0xDEADBEEF -> next cycle data_resp=1, data_rdata=0xDEADBEEF.
REQ-039 Repeat read 0x0000_0104 -> data_resp exactly 2 cycles after request, no pmem activity.
REQ-040 Write 0x0000_0104, mbe=0011, wdata=0x1234_5678 -> subsequent read returns 0xDEAD5678.
REQ-041 Read 0x0000_1104 (same index 0, different tag) -> WRITEBACK at pmem_address 0x0000_0100 with word1=0xDEAD5678, then ALLOCATE at 0x0000_1100, then data_resp.
REQ-042 Assert rst during ALLOCATE -> pmem_read=0 next cycle; later read 0x0000_0104 misses (valid cleared).
REQ-043 Read and write both high to a cached word, mbe=1111 -> data_rdata=old word, subsequent read returns new data.
